// File: rtl/usart_pkg.sv
// Shared types for the parametrised UART receiver: FSM states, parity modes, bit-timer sizing.
// Pure declarations; no clocked logic.
package usart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int calc_cnt_w(input int bps_cnt);
    return $clog2(bps_cnt);
  endfunction

endpackage

// File: rtl/usart_rx_param_if.sv
// Receiver-side bundle: serial line in, received word plus status out.
// master = receiver, slave = the serial pin driver / word consumer.
interface usart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 usart_rxd;
  logic [DATA_BITS-1:0] uart_data;
  logic                 uart_done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  usart_rxd,
    output uart_data, uart_done, parity_err, frame_err, busy
  );

  modport slave (
    output usart_rxd,
    input  uart_data, uart_done, parity_err, frame_err, busy
  );
endinterface

// File: rtl/usart_rx_sampler.sv
// Line synchroniser, bit timer and mid-bit sampler; bit_vld_o at count BPS_CNT/2, or one cycle
// after the third sample when USART_RX_MAJORITY_EN selects 2-of-3 voting. No backpressure.
module usart_rx_sampler
  import usart_pkg::*;
#(
  parameter int BPS_CNT = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  input  logic run_i,
  input  logic start_i,
  output logic line_o,
  output logic fall_o,
  output logic bit_o,
  output logic bit_vld_o
);

  localparam int              CNT_W = calc_cnt_w(BPS_CNT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BPS_CNT / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS_CNT - 1);

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Sync chain resets high so an idle line never looks like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      rx_s1_q   <= rxd_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (start_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign line_o = rx_s2_q;
  assign fall_o = rx_prev_q & ~rx_s2_q;

`ifdef USART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BPS_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] HALF_P1 = CNT_W'(BPS_CNT / 2 + 1);

  logic samp_a_q, samp_b_q, maj_q, vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
      maj_q    <= 1'b1;
      vld_q    <= 1'b0;
    end else begin
      if (cnt_q == HALF_M1) samp_a_q <= rx_s2_q;
      if (cnt_q == HALF)    samp_b_q <= rx_s2_q;
      vld_q <= run_i & (cnt_q == HALF_P1);
      if (cnt_q == HALF_P1) begin
        maj_q <= (samp_a_q & samp_b_q) | (samp_a_q & rx_s2_q) | (samp_b_q & rx_s2_q);
      end
    end
  end

  assign bit_o     = maj_q;
  assign bit_vld_o = vld_q;
`else
  assign bit_o     = rx_s2_q;
  assign bit_vld_o = run_i & (cnt_q == HALF);
`endif

endmodule

// File: rtl/usart_rx_param.sv
// Parametrised UART receiver; uart_done one cycle after the last stop-bit sample (+1 with
// USART_RX_MAJORITY_EN). No backpressure: each word is strobed once and held until the next.
module usart_rx_param
  import usart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic sys_clk,
  input logic sys_rst,
  usart_rx_param_if.master bus
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);

  if (BPS_CNT < 16) begin : g_bps_too_small
    $error("usart_rx_param: CLK_FREQ/UART_BPS must be at least 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("usart_rx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("usart_rx_param: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ferr_now;
  logic                 par_exp;

  logic line, fall, samp_bit, samp_vld, run, start;

  assign run   = (state_q == START) || (state_q == DATA) ||
                 (state_q == usart_pkg::PARITY) || (state_q == STOP);
  assign start = (state_q == IDLE) & fall;

  usart_rx_sampler #(
    .BPS_CNT (BPS_CNT)
  ) u_sampler (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .rxd_i     (bus.usart_rxd),
    .run_i     (run),
    .start_i   (start),
    .line_o    (line),
    .fall_o    (fall),
    .bit_o     (samp_bit),
    .bit_vld_o (samp_vld)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Odd parity expects the bit that makes the total count of ones odd.
  assign par_exp = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    done_d     = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ferr_now   = ferr_acc_q | ~samp_bit;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      START: begin
        if (samp_vld) state_d = samp_bit ? IDLE : DATA;
      end
      DATA: begin
        if (samp_vld) begin
          shift_d = {samp_bit, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_DATA) begin
            state_d = (PARITY != PAR_NONE) ? usart_pkg::PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      usart_pkg::PARITY: begin
        if (samp_vld) begin
          perr_acc_d = samp_bit ^ par_exp;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (samp_vld) begin
          ferr_acc_d = ferr_now;
          if (stop_idx_q == LAST_STOP) begin
            done_d  = 1'b1;
            data_d  = shift_q;
            perr_d  = perr_acc_q;
            ferr_d  = ferr_now;
            // A low final stop sample means break; park until the line recovers.
            state_d = (ferr_now & ~samp_bit) ? WAIT_IDLE : IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.uart_data  = data_q;
  assign bus.uart_done  = done_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
